// File: rtl/tt_probe_pkg.sv
// Shared types and constants for the truth-table probe.
package tt_probe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned CODE_W      = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned MAJ_SAMPLES = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/truth_table_probe.sv
// Steps a 3-input circuit through vectors 000..111 and assembles its 8-bit truth-table code.
// Define TT_PROBE_MAJORITY_EN for a 3-sample majority vote per vector.
module truth_table_probe
  import tt_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [VEC_W-1:0]     stim,
  output logic                 busy,
  output logic                 done,
  output logic [CODE_W-1:0]    code
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   shift_q, shift_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                dut_sync;
  logic                cap;
  logic                cap_bit;

`ifdef TT_PROBE_MAJORITY_EN
  logic [1:0]          smp_q, smp_d;
  logic [1:0]          vote_q, vote_d;
`endif

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dut_out),
    .q_o   (dut_sync)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    code_d  = code_q;
    stim    = '0;
    busy    = 1'b0;
    done    = 1'b0;
    cap     = 1'b0;
    cap_bit = 1'b0;
`ifdef TT_PROBE_MAJORITY_EN
    smp_d   = smp_q;
    vote_d  = vote_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          k_d     = '0;
          cnt_d   = '0;
          shift_d = '0;
`ifdef TT_PROBE_MAJORITY_EN
          smp_d   = '0;
`endif
        end
      end

      SETTLE: begin
        busy = 1'b1;
        stim = k_q;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SAMPLE: begin
        busy = 1'b1;
        stim = k_q;
`ifdef TT_PROBE_MAJORITY_EN
        if (smp_q == 2'(MAJ_SAMPLES - 1)) begin
          cap     = 1'b1;
          cap_bit = maj3(vote_q[0], vote_q[1], dut_sync);
          smp_d   = '0;
        end else begin
          vote_d[smp_q[0]] = dut_sync;
          smp_d            = smp_q + 2'd1;
        end
`else
        cap     = 1'b1;
        cap_bit = dut_sync;
`endif
        if (cap) begin
          shift_d = {shift_q[CODE_W-2:0], cap_bit};
          if (k_q == VEC_LAST) begin
            state_d = DONE;
            // code is loaded with the final assembled word on entry to DONE,
            // so it is already valid during the done pulse.
            code_d  = shift_d;
          end else begin
            state_d = SETTLE;
            k_d     = k_q + VEC_W'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      code_q  <= code_d;
    end
  end

`ifdef TT_PROBE_MAJORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      vote_q <= '0;
    end else begin
      smp_q  <= smp_d;
      vote_q <= vote_d;
    end
  end
`endif

  assign code = code_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe with a scoreboard of expected codes.
module tb_truth_table_probe;

  localparam int S = 4;
`ifdef TT_PROBE_MAJORITY_EN
  localparam int P = S + 3;
`else
  localparam int P = S + 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       dut_out;
  logic [2:0] stim;
  logic       busy;
  logic       done;
  logic [7:0] code;

  logic [7:0] tt;
  logic       glitch;
  logic [7:0] last_code;
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  // Combinational circuit under characterization: bit 7 of tt is vector 000.
  assign dut_out = tt[3'd7 - stim] ^ glitch;

  always @(negedge clk) if (rst_n === 1'b1 && done === 1'b1) done_cnt++;

  truth_table_probe #(.SETTLE_CYCLES(S)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_out (dut_out),
    .stim    (stim),
    .busy    (busy),
    .done    (done),
    .code    (code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: single start pulse; 1: start held through DONE; 2: extra pulse mid-run
  task automatic run(input logic [7:0] table_v, input int mode, input bit glitch_en,
                     input int idle_after);
    int         d0;
    logic [7:0] exp_code;
    exp_code = 8'h00;
    tt = table_v;
    d0 = done_cnt;
    exp_q.push_back(table_v);
    start = 1'b1;
    for (int e = 0; e <= 8 * P + 1; e++) begin
      tick();
      if (mode == 1) start = (e < 8 * P + 1);
      else if (mode == 2) start = (e == 20);
      else start = 1'b0;
      glitch = glitch_en && ((e % P) == (S - 2));
      if (e < 8 * P) begin
        chk("busy_run", busy, 1);
        chk("stim_vec", stim, e / P);
        chk("done_low", done, 0);
        chk("code_hold", code, last_code);
      end else if (e == 8 * P) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) exp_code = exp_q.pop_front();
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("stim_done", stim, 0);
        chk("code_new", code, exp_code);
      end else begin
        chk("done_end", done, 0);
        chk("busy_end", busy, 0);
      end
    end
    glitch = 1'b0;
    start  = 1'b0;
    chk("done_count", done_cnt - d0, 1);
    if (idle_after > 0) begin
      repeat (idle_after) tick();
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
    end
    last_code = exp_code;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tt        = 8'h00;
    glitch    = 1'b0;
    last_code = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_code", code, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run(8'h57, 0, 1'b0, 2);
    run(8'h00, 0, 1'b0, 2);
    run(8'h01, 0, 1'b0, 2);
    run(8'h7F, 0, 1'b0, 2);
    run(8'h57, 0, 1'b0, 0);
    run(8'h7F, 0, 1'b0, 2);
    run(8'h57, 1, 1'b0, 3);
    run(8'h01, 2, 1'b0, 3);

    // Reset during vector 011
    tt = 8'h57;
    exp_q.push_back(8'h57);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3 * P + 2) tick();
    chk("abort_vec", stim, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_stim", stim, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_code", code, 8'h00);
    exp_q.delete();
    last_code = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    run(8'h57, 0, 1'b0, 2);

`ifdef TT_PROBE_MAJORITY_EN
    run(8'h57, 0, 1'b1, 2);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

- Sequential characterizer for 3-input logic circuits.
- Drives all eight input vectors into a device under test in order 000 to 111, lets each one settle, and samples the single output.
- Assembles the results into the 8-bit hex truth-table code the team uses to name circuits (e.g. 0x57).
- Sits on the stimulus side of a combinational circuit module and is the reading end of the truth-table interface that such modules implement.

## Interface
- SETTLE_CYCLES, 4: cycles each vector is held before sampling; legal range 2..255.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  begin a characterization run; accepted only in IDLE.
- dut_out  input  1  output of the circuit under test; may be asynchronous.
- stim  output  3  vector to the circuit under test: {in1,in2,in3}.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a new code is valid.
- code  output  8  truth-table code of the last completed run.

## Operation
- dut_out passes through a 2-flop synchronizer before use.
- Code bit order: bit 7 = output for vector 000, bit 0 = output for vector 111.
- Example: outputs 0,1,0,1,0,1,1,1 for vectors 000..111 give 0x57.
- Shift register: internal 8-bit shift register, shifted left with the sample entering at the LSB.
- code register: loaded from the shift register only in DONE; it holds its value otherwise and across runs.
- States:
  - IDLE: stim=000, busy=0. start=1 goes to SETTLE with vector index k=0 and the settle counter cleared.
  - SETTLE: stim=k, busy=1. Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - SAMPLE: captures the synchronized dut_out into the shift register. If k<7: k+=1, go to SETTLE. If k=7: go to DONE.
  - DONE: one cycle. code<=shift register, done=1, busy=0, stim=000, then go to IDLE.
- start while busy=1 or in DONE is ignored; no queuing.
- Reset at any time: run aborted, state IDLE, partial result discarded.
- Reset values: stim=000, busy=0, done=0, code=0x00, shift register=0, synchronizer flops=0.

## Timing
- The start-accept edge is edge 0.
- stim=000 and busy=1 from edge 0.
- Vector k is applied from edge k*(SETTLE_CYCLES+1).
- Sample for vector k is taken at edge k*(SETTLE_CYCLES+1)+SETTLE_CYCLES+1.
- done=1 for exactly the cycle after edge 8*(SETTLE_CYCLES+1). code carries the new value from that same edge.
- busy falls with the done edge.
- The 2-cycle synchronizer latency is absorbed by SETTLE_CYCLES≥2. The DUT must settle within SETTLE_CYCLES-2 cycles.
- The settle counter is $clog2(SETTLE_CYCLES+1) bits wide and saturates; it never wraps mid-vector.
- The vector index is 3 bits. The transition out of k=7 is by state, not by wrap.

## Configuration
- TT_PROBE_MAJORITY_EN defined:
  - SAMPLE lasts 3 consecutive cycles.
  - The captured bit is the majority of the three synchronized samples.
  - Per-vector period becomes SETTLE_CYCLES+3.
  - done is asserted the cycle after edge 8*(SETTLE_CYCLES+3).
- Undefined: single-sample SAMPLE as above. No vote logic is synthesized.

## Structure
- Package tt_probe_pkg contains:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - NUM_VECTORS=8, CODE_W=8, VEC_W=3;
  - MAJ_SAMPLES=3.
- Sub-module tt_sync2: 2-flop synchronizer with asynchronous active-low reset to 0, instantiated once for dut_out.

## Test plan
- Combinational model of 0x57, SETTLE_CYCLES=4, pulse start → code=0x57, done pulse 1 cycle after edge 40, busy high edges 0–40.
- Models of constant 0, AND3 and OR3 → code=0x00, 0x01, 0x7F respectively; stim steps 000→111, each held 5 cycles.
- start held high for the whole run and pulsed again mid-run → exactly one run and one done; the next start after IDLE runs normally.
- rst_n low during vector 011 → stim=000, busy=0, done=0, code=0x00 immediately; next run on 0x57 → 0x57.
- With TT_PROBE_MAJORITY_EN: a 1-cycle glitch on dut_out inside each 3-cycle sample window on 0x57 → code=0x57, done 1 cycle after edge 56.
- Back-to-back runs on 0x57 then OR3 → code stays 0x57 throughout the second run until its done, then becomes 0x7F.
